// File: rtl/ofdm_buf_pkg.sv
// ofdm_buf_pkg: shared bank-state type and default frame size for the OFDM ping-pong buffer.
// Revision: 1.0
`default_nettype none

package ofdm_buf_pkg;

  localparam int OFDM_CODED_BITS = 576;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

endpackage

`default_nettype wire

// File: rtl/ppbuf_ram.sv
// ppbuf_ram: 2*DEPTH x WIDTH simple dual-port RAM, one write port, one registered read port.
// Revision: 1.0
`default_nettype none

module ppbuf_ram
  import ofdm_buf_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = OFDM_CODED_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int WORDS = 2 * DEPTH;
  localparam int IW    = $clog2(WORDS);

  logic [WIDTH-1:0] mem [WORDS];

  // Banks are packed back to back so a non-power-of-two DEPTH wastes no words.
  function automatic logic [IW-1:0] word_index(input logic bank, input logic [AW-1:0] addr);
    return bank ? (IW'(DEPTH) + IW'(addr)) : IW'(addr);
  endfunction

  always_ff @(posedge clk) begin
    if (we) begin
      mem[word_index(wr_bank, wr_addr)] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[word_index(rd_bank, rd_addr)];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ofdm_pingpong_buffer.sv
// ofdm_pingpong_buffer: two-bank frame buffer with commit/release bank handover.
// Optional sticky error flags when PPBUF_ERR_EN is defined. Revision: 1.0
`default_nettype none

module ofdm_pingpong_buffer
  import ofdm_buf_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = OFDM_CODED_BITS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_commit,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_release,
  output logic             rd_avail,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       fill_level,
  output logic [1:0]       err_flags
);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [1:0]  fill_q, fill_d;

  logic wr_in_range, rd_in_range;
  logic write_ok, read_ok, commit_ok, release_ok;

  assign wr_ready = (bank_q[wr_bank_q] == BANK_EMPTY);
  assign rd_avail = (bank_q[rd_bank_q] == BANK_FULL);

  assign wr_in_range = ({1'b0, wr_addr} < (AW + 1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));

  assign write_ok   = wr_en & wr_ready & wr_in_range;
  assign read_ok    = rd_en & rd_avail & rd_in_range;
  assign commit_ok  = wr_commit & wr_ready;
  assign release_ok = rd_release & rd_avail;

  // A committing bank is EMPTY and a releasing bank is FULL, so both can never hit the same bank.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    fill_d    = fill_q;
    if (commit_ok) begin
      bank_d[wr_bank_q] = BANK_FULL;
      wr_bank_d         = ~wr_bank_q;
    end
    if (release_ok) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end
    case ({commit_ok, release_ok})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= BANK_EMPTY;
      bank_q[1] <= BANK_EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      fill_q    <= 2'd0;
      rd_valid  <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      fill_q    <= fill_d;
      rd_valid  <= read_ok;
    end
  end

  assign fill_level = fill_q;

  ppbuf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (write_ok),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (read_ok),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef PPBUF_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_q | {(rd_en | rd_release) & ~rd_avail, (wr_en | wr_commit) & ~wr_ready};
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ofdm_pingpong_buffer.sv
// tb_ofdm_pingpong_buffer: directed and random stimulus against a frame-level reference model.
// Revision: 1.0
`default_nettype none

module tb_ofdm_pingpong_buffer;
  import ofdm_buf_pkg::*;

  localparam int WIDTH = 1;
  localparam int DEPTH = OFDM_CODED_BITS;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_commit;
  logic             wr_ready;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_release;
  logic             rd_avail;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [1:0]       fill_level;
  logic [1:0]       err_flags;

  ofdm_pingpong_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_release (rd_release),
    .rd_avail   (rd_avail),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fill_level (fill_level),
    .err_flags  (err_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which banks hold a frame, which bank each side owns, and the frame contents.
  bit               full_m [2];
  int               wb_m, rb_m;
  logic [WIDTH-1:0] mem_m   [2][DEPTH];
  bit               known_m [2][DEPTH];
  bit               exp_valid;
  logic [WIDTH-1:0] exp_data;
  bit               data_known;
  logic [1:0]       err_m;

  task automatic model_reset();
    full_m[0]  = 1'b0;
    full_m[1]  = 1'b0;
    wb_m       = 0;
    rb_m       = 0;
    exp_valid  = 1'b0;
    exp_data   = '0;
    data_known = 1'b1;
    err_m      = 2'b00;
  endtask

  task automatic check_outputs(input string ctx);
    int full_cnt;
    full_cnt = int'(full_m[0]) + int'(full_m[1]);
    check({ctx, ":wr_ready"},   32'(wr_ready),   32'(!full_m[wb_m]));
    check({ctx, ":rd_avail"},   32'(rd_avail),   32'(full_m[rb_m]));
    check({ctx, ":fill_level"}, 32'(fill_level), 32'(full_cnt));
    check({ctx, ":rd_valid"},   32'(rd_valid),   32'(exp_valid));
    if (data_known) check({ctx, ":rd_data"}, 32'(rd_data), 32'(exp_data));
`ifdef PPBUF_ERR_EN
    check({ctx, ":err_flags"}, 32'(err_flags), 32'(err_m));
`else
    check({ctx, ":err_flags"}, 32'(err_flags), 32'(0));
`endif
  endtask

  task automatic step(input string ctx, input bit we, input int wa, input logic [WIDTH-1:0] wd,
                      input bit wc, input bit re, input int ra, input bit rr);
    bit ready, avail;
    wr_en      = we;
    wr_addr    = AW'(wa);
    wr_data    = wd;
    wr_commit  = wc;
    rd_en      = re;
    rd_addr    = AW'(ra);
    rd_release = rr;
    @(posedge clk);
    ready = !full_m[wb_m];
    avail = full_m[rb_m];
    if (we && ready && wa < DEPTH) begin
      mem_m[wb_m][wa]   = wd;
      known_m[wb_m][wa] = 1'b1;
    end
    if (re && avail && ra < DEPTH) begin
      exp_valid  = 1'b1;
      exp_data   = mem_m[rb_m][ra];
      data_known = known_m[rb_m][ra];
    end else begin
      exp_valid = 1'b0;
    end
`ifdef PPBUF_ERR_EN
    if ((we || wc) && !ready) err_m[0] = 1'b1;
    if ((re || rr) && !avail) err_m[1] = 1'b1;
`endif
    if (wc && ready) begin
      full_m[wb_m] = 1'b1;
      wb_m         = 1 - wb_m;
    end
    if (rr && avail) begin
      full_m[rb_m] = 1'b0;
      rb_m         = 1 - rb_m;
    end
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
  endtask

  // Asserts reset between edges with whatever request is currently driven, then clears it.
  task automatic pulse_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(ctx);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) known_m[b][a] = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 0, '0, 0, 0, 0, 0);

    // Full frame of alternating bits into bank0, then read it all back.
    for (int i = 0; i < DEPTH; i++) step("fill0", 1, i, WIDTH'(i & 1), 0, 0, 0, 0);
    step("commit0", 0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step("read0", 0, 0, '0, 0, 1, i, 0);
      check("read0:alt", 32'(rd_data), 32'(i & 1));
    end

    // Commit bank1 and release bank0 in the same cycle.
    step("w1a5", 1, 5, WIDTH'(1), 0, 0, 0, 0);
    step("w1a7", 1, 7, WIDTH'(0), 0, 0, 0, 0);
    step("swap", 0, 0, '0, 1, 0, 0, 1);
    check("swap:fill", 32'(fill_level), 32'd1);

    // Fill bank0, then both banks full: extra write must be ignored.
    step("w0a10", 1, 10, WIDTH'(1), 0, 0, 0, 0);
    step("commit_b0", 1, 11, WIDTH'(0), 1, 0, 0, 0);
    check("both_full:fill", 32'(fill_level), 32'd2);
    step("ignored_wr", 1, 5, WIDTH'(0), 0, 0, 0, 0);
    step("rd1a5", 0, 0, '0, 0, 1, 5, 0);
    check("rd1a5:data", 32'(rd_data), 32'd1);
    step("rel1", 0, 0, '0, 0, 0, 0, 1);
    step("rd_rel0", 0, 0, '0, 0, 1, 10, 1);
    check("rd_rel0:data", 32'(rd_data), 32'd1);
    step("rd_none", 0, 0, '0, 0, 1, 3, 0);
    step("rd_oor", 0, 0, '0, 0, 0, 0, 0);

    // Random traffic, including out-of-range addresses and collisions.
    for (int n = 0; n < 4000; n++) begin
      step("rand",
           $urandom_range(0, 3) != 0, int'($urandom_range(0, DEPTH + 3)), WIDTH'($urandom),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, DEPTH + 3)),
           $urandom_range(0, 29) == 0);
    end

    // Reset mid-write at address 300.
    step("pre_rst", 0, 0, '0, 0, 0, 0, 0);
    for (int i = 290; i < 300; i++) step("prew", 1, i, WIDTH'(i & 1), 0, 0, 0, 0);
    wr_en = 1; wr_addr = AW'(300); wr_data = WIDTH'(1);
    pulse_reset("rst_mid_write");
    step("post_rst1", 0, 0, '0, 0, 1, 0, 1);

    // Reset mid-read of a committed frame.
    for (int i = 0; i < 4; i++) step("prer", 1, i, WIDTH'(i & 1), 0, 0, 0, 0);
    step("prer_commit", 0, 0, '0, 1, 0, 0, 0);
    step("prer_rd", 0, 0, '0, 0, 1, 1, 0);
    rd_en = 1; rd_addr = AW'(2);
    pulse_reset("rst_mid_read");
    step("post_rst2", 0, 0, '0, 0, 1, 2, 1);
    step("post_rst3", 0, 0, '0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
